// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron learning controller and its datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package perceptron_pkg;

  // Default signed feature width used by feeder, controller and datapath
  localparam int DATA_W = 8;

  // Sample feeder sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRAIN = 3'd1,
    S_EOF   = 3'd2,
    S_TEST  = 3'd3,
    S_EOI   = 3'd4
  } feeder_state_t;

  // Target encoding: stored bit 1 means +1, bit 0 means -1
  localparam logic T_POS = 1'b1;
  localparam logic T_NEG = 1'b0;

  // Signed value of an encoded target, for arithmetic in the learning datapath
  function automatic int t_value(input logic t);
    return (t == T_POS) ? 1 : -1;
  endfunction

endpackage

// File: rtl/feeder_mem.sv
// Sample store: synchronous write, combinational read register file.
// Latency: read data follows raddr in the same cycle; a write is visible from the next cycle.
// Backpressure: none; a write is always accepted, out-of-range addresses are dropped and read as zero.
module feeder_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             waddr_ok;
  logic             raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_L);

  // Storage is deliberately not reset so a loaded data set survives a session abort
  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // A read on the same edge as a write sees the old word
  assign rdata = raddr_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/perceptron_sample_feeder.sv
// Training/test sample feeder: presents one stored sample per ldX pulse, flags EOF/EOI, counts epochs.
// Latency: sample appears on x1/x2/t one cycle after ldX; EOF/EOI are registered off the same edge.
// Backpressure: none; ldX is the only pacing, writes are accepted in any state. FEEDER_EPOCH_LIMIT_EN adds MAX_EPOCH/limit_hit.
module perceptron_sample_feeder #(
  parameter int DATA_W      = perceptron_pkg::DATA_W,
  parameter int TRAIN_DEPTH = 16,
  parameter int TEST_DEPTH  = 8,
  parameter int ADDR_W      = 4,
  parameter int EPOCH_W     = 8
`ifdef FEEDER_EPOCH_LIMIT_EN
  ,parameter int MAX_EPOCH  = 100
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_x1,
  input  logic signed [DATA_W-1:0] wr_x2,
  input  logic                     wr_t,
  input  logic [ADDR_W:0]          train_cnt,
  input  logic [ADDR_W:0]          test_cnt,
  input  logic                     start,
  input  logic                     ldX,
  input  logic                     test_mode,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic                     t,
  output logic                     EOF,
  output logic                     EOI,
  output logic [EPOCH_W-1:0]       epoch,
  output logic                     busy
`ifdef FEEDER_EPOCH_LIMIT_EN
  ,output logic                    limit_hit
`endif
);

  import perceptron_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TRAIN_DEPTH_L = CNT_W'(TRAIN_DEPTH);
  localparam logic [CNT_W-1:0]   TEST_DEPTH_L  = CNT_W'(TEST_DEPTH);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE    = EPOCH_W'(1);

  feeder_state_t       state;
  logic [CNT_W-1:0]    ptr;
  logic [CNT_W-1:0]    train_last;
  logic [CNT_W-1:0]    test_last;
  logic [2*DATA_W:0]   train_wdata;
  logic [2*DATA_W:0]   train_rdata;
  logic [2*DATA_W-1:0] test_wdata;
  logic [2*DATA_W-1:0] test_rdata;
  logic [EPOCH_W-1:0]  epoch_inc;
  logic                eof_to_test;

  // Counts of zero run a single sample; counts beyond the memory are held to its depth
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] depth);
    if (cnt == '0) begin
      return ONE;
    end else if (cnt > depth) begin
      return depth;
    end else begin
      return cnt;
    end
  endfunction

  assign train_wdata = {wr_t, wr_x1, wr_x2};
  assign test_wdata  = {wr_x1, wr_x2};

  feeder_mem #(
    .DEPTH  (TRAIN_DEPTH),
    .WIDTH  (2*DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_train_mem (
    .clk   (clk),
    .we    (wr_en & ~wr_sel),
    .waddr (wr_addr),
    .wdata (train_wdata),
    .raddr (ptr[ADDR_W-1:0]),
    .rdata (train_rdata)
  );

  feeder_mem #(
    .DEPTH  (TEST_DEPTH),
    .WIDTH  (2*DATA_W),
    .ADDR_W (ADDR_W)
  ) u_test_mem (
    .clk   (clk),
    .we    (wr_en & wr_sel),
    .waddr (wr_addr),
    .wdata (test_wdata),
    .raddr (ptr[ADDR_W-1:0]),
    .rdata (test_rdata)
  );

  // Epoch count after an S_EOF exit, held at all-ones once saturated
  assign epoch_inc = (epoch == '1) ? epoch : epoch + EPOCH_ONE;

`ifdef FEEDER_EPOCH_LIMIT_EN
  localparam logic [EPOCH_W-1:0] MAX_EPOCH_L = EPOCH_W'(MAX_EPOCH);
  logic limit_reached;
  // Reaching the epoch ceiling ends training even if the controller has not learned yet
  assign limit_reached = (epoch_inc >= MAX_EPOCH_L);
  assign eof_to_test   = test_mode | limit_reached;
`else
  assign eof_to_test   = test_mode;
`endif

  // Sequencer with registered sample, flag and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      train_last <= '0;
      test_last  <= '0;
      x1         <= '0;
      x2         <= '0;
      t          <= T_NEG;
      EOF        <= 1'b0;
      EOI        <= 1'b0;
      epoch      <= '0;
      busy       <= 1'b0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      limit_hit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr        <= '0;
            train_last <= clamp_cnt(train_cnt, TRAIN_DEPTH_L) - ONE;
            test_last  <= clamp_cnt(test_cnt, TEST_DEPTH_L) - ONE;
            busy       <= 1'b1;
            state      <= test_mode ? S_TEST : S_TRAIN;
`ifdef FEEDER_EPOCH_LIMIT_EN
            limit_hit  <= 1'b0;
`endif
          end
        end

        S_TRAIN: begin
          if (ldX) begin
            t   <= train_rdata[2*DATA_W];
            x1  <= train_rdata[2*DATA_W-1:DATA_W];
            x2  <= train_rdata[DATA_W-1:0];
            ptr <= ptr + ONE;
            if (ptr == train_last) begin
              EOF   <= 1'b1;
              state <= S_EOF;
            end
          end
        end

        S_EOF: begin
          // start here acts as ldX; the last sample stays on the outputs
          if (ldX || start) begin
            EOF   <= 1'b0;
            epoch <= epoch_inc;
            ptr   <= '0;
            state <= eof_to_test ? S_TEST : S_TRAIN;
`ifdef FEEDER_EPOCH_LIMIT_EN
            if (limit_reached) begin
              limit_hit <= 1'b1;
            end
`endif
          end
        end

        S_TEST: begin
          if (ldX) begin
            x1  <= test_rdata[2*DATA_W-1:DATA_W];
            x2  <= test_rdata[DATA_W-1:0];
            t   <= T_NEG;
            ptr <= ptr + ONE;
            if (ptr == test_last) begin
              EOI   <= 1'b1;
              state <= S_EOI;
            end
          end
        end

        S_EOI: begin
          EOI   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          EOF   <= 1'b0;
          EOI   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_sample_feeder.sv
// Bench for perceptron_sample_feeder: directed table, hand sequences, randomized run against a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_perceptron_sample_feeder;

  localparam int DATA_W = 8;
  localparam int TRAIN_DEPTH = 16;
  localparam int TEST_DEPTH = 8;
  localparam int ADDR_W = 4;
  localparam int EPOCH_W = 8;
  localparam int MAXE = 2;

  logic clk = 1'b0;
  logic rst, wr_en, wr_sel, wr_t, start, ldX, test_mode;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_x1, wr_x2;
  logic [ADDR_W:0] train_cnt, test_cnt;
  logic signed [DATA_W-1:0] x1, x2;
  logic t, EOF, EOI, busy;
  logic [EPOCH_W-1:0] epoch;
`ifdef FEEDER_EPOCH_LIMIT_EN
  logic limit_hit;
`endif

  always #5 clk = ~clk;

  perceptron_sample_feeder #(
    .DATA_W(DATA_W), .TRAIN_DEPTH(TRAIN_DEPTH), .TEST_DEPTH(TEST_DEPTH),
    .ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W)
`ifdef FEEDER_EPOCH_LIMIT_EN
    ,.MAX_EPOCH(MAXE)
`endif
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t), .train_cnt(train_cnt), .test_cnt(test_cnt),
    .start(start), .ldX(ldX), .test_mode(test_mode), .x1(x1), .x2(x2), .t(t),
    .EOF(EOF), .EOI(EOI), .epoch(epoch), .busy(busy)
`ifdef FEEDER_EPOCH_LIMIT_EN
    ,.limit_hit(limit_hit)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Shadow copies of what the bench has written into the two memories
  logic signed [7:0] tr_x1 [TRAIN_DEPTH];
  logic signed [7:0] tr_x2 [TRAIN_DEPTH];
  logic              tr_t  [TRAIN_DEPTH];
  logic signed [7:0] te_x1 [TEST_DEPTH];
  logic signed [7:0] te_x2 [TEST_DEPTH];

  // Reference model: position within the current pass over a sample list
  bit m_busy, m_test, m_eof, m_eoi, m_limit;
  int m_idx, m_tn, m_sn, m_epoch;
  logic signed [7:0] m_x1, m_x2;
  logic m_t;

  typedef struct {
    logic start, ld, tm;
    logic signed [7:0] x1, x2;
    logic t, eof, eoi;
    int   ep;
    logic busy;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic signed [7:0] ex1, input logic signed [7:0] ex2,
                           input logic et, input logic eeof, input logic eeoi, input int eep, input logic ebusy);
    check({tag, ".x1"}, x1, ex1);
    check({tag, ".x2"}, x2, ex2);
    check({tag, ".t"}, t, et);
    check({tag, ".EOF"}, EOF, eeof);
    check({tag, ".EOI"}, EOI, eeoi);
    check({tag, ".epoch"}, epoch, eep);
    check({tag, ".busy"}, busy, ebusy);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input logic signed [7:0] a, input logic signed [7:0] b, input logic tt);
    wr_en = 1'b1; wr_sel = sel; wr_addr = ADDR_W'(addr); wr_x1 = a; wr_x2 = b; wr_t = tt;
    cyc();
    wr_en = 1'b0;
    if (!sel) begin tr_x1[addr] = a; tr_x2[addr] = b; tr_t[addr] = tt; end
    else begin te_x1[addr] = a; te_x2[addr] = b; end
  endtask

  task automatic ld_step(input logic tm);
    ldX = 1'b1; test_mode = tm;
    cyc();
    ldX = 1'b0;
  endtask

  function automatic int clampc(input int c, input int d);
    return (c == 0) ? 1 : ((c > d) ? d : c);
  endfunction

  // One clock of the model; memories are read before any same-cycle write is applied
  task automatic model_step(input bit st, input bit ld, input bit tm, input int tc, input int sc);
    if (m_eoi) begin
      m_eoi = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_test = tm; m_idx = 0; m_limit = 0;
        m_tn = clampc(tc, TRAIN_DEPTH); m_sn = clampc(sc, TEST_DEPTH);
      end
    end else if (m_eof) begin
      if (ld || st) begin
        m_eof = 0; m_idx = 0; m_test = tm;
        if (m_epoch < 255) m_epoch++;
`ifdef FEEDER_EPOCH_LIMIT_EN
        if (m_epoch >= MAXE) begin m_test = 1; m_limit = 1; end
`endif
      end
    end else if (ld) begin
      if (!m_test) begin
        m_x1 = tr_x1[m_idx]; m_x2 = tr_x2[m_idx]; m_t = tr_t[m_idx];
        m_idx++;
        if (m_idx == m_tn) m_eof = 1;
      end else begin
        m_x1 = te_x1[m_idx]; m_x2 = te_x2[m_idx]; m_t = 1'b0;
        m_idx++;
        if (m_idx == m_sn) m_eoi = 1;
      end
    end
  endtask

  initial begin
    bit r_st, r_ld, r_tm, r_we, r_sel;
    int r_addr, r_tc, r_sc;
    logic signed [7:0] r_a, r_b;
    logic r_t;

    rst = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_t = 0;
    start = 0; ldX = 0; test_mode = 0; train_cnt = 5'd3; test_cnt = 5'd2;
    #3;
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
`ifdef FEEDER_EPOCH_LIMIT_EN
    check("reset.limit_hit", limit_hit, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    wr(0, 0, 5, -3, 1);
    wr(0, 1, -2, 4, 0);
    wr(0, 2, 7, 7, 1);
    wr(1, 0, 10, -20, 0);
    wr(1, 1, -1, 127, 0);

    // start, ld, tm | x1, x2, t | EOF, EOI | epoch | busy
    tbl[0]  = '{1, 0, 0,   0,   0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 0,   5,  -3, 1, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 0,  -2,   4, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0,   7,   7, 1, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0,   7,   7, 1, 1, 0, 0, 1};
    tbl[5]  = '{0, 1, 0,   7,   7, 1, 0, 0, 1, 1};
    tbl[6]  = '{0, 1, 0,   5,  -3, 1, 0, 0, 1, 1};
    tbl[7]  = '{0, 1, 1,  -2,   4, 0, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 1,   7,   7, 1, 1, 0, 1, 1};
    tbl[9]  = '{0, 1, 1,   7,   7, 1, 0, 0, 2, 1};
    tbl[10] = '{0, 1, 0,  10, -20, 0, 0, 0, 2, 1};
    tbl[11] = '{0, 1, 0,  -1, 127, 0, 0, 1, 2, 1};
    tbl[12] = '{0, 1, 0,  -1, 127, 0, 0, 0, 2, 0};
    tbl[13] = '{0, 1, 0,  -1, 127, 0, 0, 0, 2, 0};
    tbl[14] = '{0, 0, 0,  -1, 127, 0, 0, 0, 2, 0};

    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start; ldX = tbl[i].ld; test_mode = tbl[i].tm;
      cyc();
      check_out($sformatf("tbl%0d", i), tbl[i].x1, tbl[i].x2, tbl[i].t,
                tbl[i].eof, tbl[i].eoi, tbl[i].ep, tbl[i].busy);
    end
    start = 0; ldX = 0; test_mode = 0;

    // Asynchronous reset in the middle of a training pass
    start = 1; cyc(); start = 0;
    ld_step(0);
    ld_step(0);
    check("pre_rst.x1", x1, -2);
    #2 rst = 1'b1;
    #1 check_out("mid_rst", 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    start = 1; cyc(); start = 0;
    ld_step(0);
    check_out("restart", 5, -3, 1, 0, 0, 0, 1);

    // Same-address write while reading entry 1: old word is presented, new one next epoch
    ldX = 1; wr_en = 1; wr_sel = 0; wr_addr = 4'd1; wr_x1 = 33; wr_x2 = -44; wr_t = 1;
    cyc();
    ldX = 0; wr_en = 0;
    tr_x1[1] = 33; tr_x2[1] = -44; tr_t[1] = 1;
    check_out("rbw_old", -2, 4, 0, 0, 0, 0, 1);
    ld_step(0); check_out("rbw_last", 7, 7, 1, 1, 0, 0, 1);
    ld_step(0); check_out("rbw_exit", 7, 7, 1, 0, 0, 1, 1);
    ld_step(0); check_out("rbw_e0", 5, -3, 1, 0, 0, 1, 1);
    ld_step(0); check_out("rbw_new", 33, -44, 1, 0, 0, 1, 1);
    ld_step(0); check_out("rbw_eof", 7, 7, 1, 1, 0, 1, 1);
    ld_step(1); check_out("to_test", 7, 7, 1, 0, 0, 2, 1);
    ld_step(0); check_out("test0", 10, -20, 0, 0, 0, 2, 1);
    ld_step(0); check_out("test1", -1, 127, 0, 0, 1, 2, 1);
    cyc();      check_out("idle", -1, 127, 0, 0, 0, 2, 0);

`ifdef FEEDER_EPOCH_LIMIT_EN
    // Epoch ceiling forces the test set even while test_mode stays low
    rst = 1; cyc(); rst = 0;
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 3; i++) ld_step(0);
    ld_step(0);
    check("lim1.limit_hit", limit_hit, 0);
    for (int i = 0; i < 3; i++) ld_step(0);
    check("lim.EOF", EOF, 1);
    ld_step(0);
    check("lim2.epoch", epoch, 2);
    check("lim2.limit_hit", limit_hit, 1);
    ld_step(0);
    check_out("lim_test0", 10, -20, 0, 0, 0, 2, 1);
    ld_step(0);
    cyc();
    check("lim_idle.busy", busy, 0);
    check("lim_idle.limit_hit", limit_hit, 1);
    start = 1; test_mode = 1; cyc(); start = 0; test_mode = 0;
    check("lim_start.limit_hit", limit_hit, 0);
`endif

    // Randomized run against the model
    rst = 1; cyc(); rst = 0;
    m_busy = 0; m_test = 0; m_eof = 0; m_eoi = 0; m_limit = 0;
    m_idx = 0; m_tn = 1; m_sn = 1; m_epoch = 0; m_x1 = 0; m_x2 = 0; m_t = 0;
    for (int i = 0; i < TRAIN_DEPTH; i++) wr(0, i, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < TEST_DEPTH; i++) wr(1, i, 8'($urandom), 8'($urandom), 1'b0);

    for (int n = 0; n < 2500; n++) begin
      r_st  = (!m_busy && ($urandom % 4 == 0)) || ($urandom % 16 == 0);
      r_ld  = ($urandom % 2) == 0;
      r_tm  = ($urandom % 4) == 0;
      r_we  = ($urandom % 4) == 0;
      r_sel = ($urandom % 2) == 0;
      r_addr = r_sel ? $urandom_range(0, TEST_DEPTH - 1) : $urandom_range(0, TRAIN_DEPTH - 1);
      r_a = 8'($urandom); r_b = 8'($urandom); r_t = 1'($urandom);
      r_tc = $urandom_range(0, TRAIN_DEPTH);
      r_sc = $urandom_range(0, TEST_DEPTH);
      start = r_st; ldX = r_ld; test_mode = r_tm;
      train_cnt = 5'(r_tc); test_cnt = 5'(r_sc);
      wr_en = r_we; wr_sel = r_sel; wr_addr = 4'(r_addr); wr_x1 = r_a; wr_x2 = r_b; wr_t = r_t;
      model_step(r_st, r_ld, r_tm, r_tc, r_sc);
      if (r_we) begin
        if (!r_sel) begin tr_x1[r_addr] = r_a; tr_x2[r_addr] = r_b; tr_t[r_addr] = r_t; end
        else begin te_x1[r_addr] = r_a; te_x2[r_addr] = r_b; end
      end
      cyc();
      check_out($sformatf("rnd%0d", n), m_x1, m_x2, m_t, m_eof, m_eoi, m_epoch, m_busy);
`ifdef FEEDER_EPOCH_LIMIT_EN
      check($sformatf("rnd%0d.limit_hit", n), limit_hit, m_limit);
`endif
    end
    start = 0; ldX = 0; wr_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
